sram_arbiter: RTL
=================

// Module: sram_arbiter
// PURPOSE
//  Shares one sram_controller instance among NREQ requesters (e.g. I-fetch, D-cache fill/writeback).
//  Arbitrates round-robin, latches the winner's command, drives read/write to the controller and
//  holds them until done, then returns a one-cycle ack with registered read data.
//  Sits between the cache miss handlers and main_memory.
// PARAMETERS
//  NREQ     2   number of requesters (2..4)
//  AW       15  address width
//  DW       32  data width
//  TO_CYC   31  WAIT-state cycles before timeout (only with SRAM_ARB_TIMEOUT_EN)
// PORTS
//  clk        in   1        clock; all state changes on rising edge
//  reset      in   1        synchronous, active-high
//  req        in   NREQ     request per requester; held high until its ack
//  we         in   NREQ     1=write, 0=read, per requester
//  addr       in   NREQ*AW  packed addresses, requester i at [i*AW +: AW]
//  wdata      in   NREQ*DW  packed write data
//  ack        out  NREQ     one-hot, one-cycle completion pulse
//  rdata      out  DW       read data, valid in the ack cycle
//  err        out  1        timeout flag, valid in the ack cycle
//  mem_read   out  1        to controller read
//  mem_write  out  1        to controller write
//  mem_addr   out  AW       latched address
//  mem_wdata  out  DW       latched write data
//  mem_done   in   1        controller done (single-cycle pulse)
//  mem_rdata  in   DW       SRAM read data, sampled when mem_done=1
// BEHAVIOUR
//  - Reset: state=IDLE, ptr=0, ack=0, err=0, rdata=0, mem_read=mem_write=0, mem_addr=mem_wdata=0.
//  - FSM states: IDLE, ISSUE, WAIT, RESP.
//  - IDLE: if any req, grant the first set bit searching from ptr upward, wrapping. Latch
//    gid/we/addr/wdata. Next state is ISSUE. Otherwise stay in IDLE.
//  - ISSUE: assert mem_write=we_l or mem_read=~we_l, never both. Next state is WAIT.
//  - WAIT: hold mem_read/mem_write/addr/wdata constant. On mem_done: capture mem_rdata
//    (reads; writes capture 0), drop mem_read/mem_write, go to RESP.
//  - RESP: ack[gid]=1 for exactly one cycle. Set ptr = (gid+1) mod NREQ. Next state is IDLE.
//  - Latency: req at IDLE edge N gives mem_* at N+1. mem_done at edge M gives ack at M+1.
//    Minimum 4 cycles req->ack; back-to-back grants are separated by one IDLE cycle.
//  - req dropped after grant: operation still completes and ack still issues.
//    req sampled only in IDLE.
//  - Simultaneous reqs: strict round-robin.
//    Never grant the same requester twice while another is waiting.
//  - mem_done outside WAIT is ignored.
//  - Reset mid-operation aborts immediately to reset values. The controller is reset by
//    the same signal.
// CONFIGURATION
//  SRAM_ARB_TIMEOUT_EN defined:
//  - A 5-bit watchdog counts WAIT cycles.
//  - At TO_CYC with no mem_done: go to RESP with err=1, rdata=0, and drop mem_read/mem_write.
//  - The counter clears on entry to ISSUE.
//  SRAM_ARB_TIMEOUT_EN undefined:
//  - WAIT exits only on mem_done; err is tied to 0.
// STRUCTURE
//  - Shared package/header sram_arb_defs: state encodings (IDLE=2'b00, ISSUE=2'b01,
//    WAIT=2'b10, RESP=2'b11) and default AW/DW.
//  - Sub-module rr_arbiter: combinational one-hot grant from req and ptr, plus any_req.
//  - The FSM, latches and watchdog stay in sram_arbiter.
// TESTING
//  1. reset held 2 cycles, then released -> all outputs 0, state IDLE.
//  2. Read from req0, addr=0x0040, controller done after 10 cycles with mem_rdata=0xDEADBEEF
//     -> mem_read high 11 cycles, mem_write=0, ack=2'b01 one cycle later,
//     rdata=0xDEADBEEF, err=0.
//  3. req=2'b11 both held, req0 write, req1 read -> grant order 0,1,0,1.
//     No back-to-back same grant; mem_write/mem_read match each grantee's we.
//  4. req1 drops one cycle after grant -> op completes, ack=2'b10 still pulses,
//     next grant goes to req0.
//  5. reset asserted in WAIT -> next cycle mem_read=0, ack=0, ptr=0;
//     a fresh req0 is granted normally.
//  6. (SRAM_ARB_TIMEOUT_EN) mem_done never asserts -> after 31 WAIT cycles ack pulses
//     with err=1, rdata=0, mem_read dropped.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the SRAM arbiter: FSM state encodings and default bus widths.
package sram_arb_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } arb_state_t;

    localparam int DEF_AW = 15;
    localparam int DEF_DW = 32;

endpackage

// File: rtl/sram_arbiter_rr.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   gid,
    output logic            any_req
);

    int   idx;
    logic found;

    always_comb begin
        gnt   = '0;
        gid   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gid      = PW'(idx);
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one SRAM controller among NREQ requesters.
// Optional WAIT-state watchdog enabled by defining SRAM_ARB_TIMEOUT_EN.
module sram_arbiter
    import sram_arb_defs::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = DEF_AW,
    parameter int DW   = DEF_DW
`ifdef SRAM_ARB_TIMEOUT_EN
    ,
    parameter int TO_CYC = 31
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]  ack,
    output logic [DW-1:0]    rdata,
    output logic             err,
    output logic             mem_read,
    output logic             mem_write,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_wdata,
    input  logic             mem_done,
    input  logic [DW-1:0]    mem_rdata,
    output logic [1:0]       dbg_state
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t      state_q;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   gid_q;
    logic            we_q;
    logic [NREQ-1:0] ack_q;
    logic [DW-1:0]   rdata_q;
    logic            mem_read_q;
    logic            mem_write_q;
    logic [AW-1:0]   mem_addr_q;
    logic [DW-1:0]   mem_wdata_q;

    logic [NREQ-1:0] gnt;
    logic [PW-1:0]   gnt_id;
    logic            any_req;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
        .req     (req),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gid     (gnt_id),
        .any_req (any_req)
    );

`ifdef SRAM_ARB_TIMEOUT_EN
    logic [4:0] wd_q;
    logic       err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            gid_q       <= '0;
            we_q        <= 1'b0;
            ack_q       <= '0;
            rdata_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef SRAM_ARB_TIMEOUT_EN
            wd_q        <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            ack_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        gid_q       <= gnt_id;
                        we_q        <= we[gnt_id];
                        mem_addr_q  <= addr[int'(gnt_id)*AW +: AW];
                        mem_wdata_q <= wdata[int'(gnt_id)*DW +: DW];
`ifdef SRAM_ARB_TIMEOUT_EN
                        wd_q        <= '0;
                        err_q       <= 1'b0;
`endif
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    mem_write_q <= we_q;
                    mem_read_q  <= ~we_q;
                    state_q     <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Writes report zero so stale bus data never leaks to a writer.
                    if (mem_done) begin
                        rdata_q     <= we_q ? '0 : mem_rdata;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        state_q     <= ST_RESP;
                    end
`ifdef SRAM_ARB_TIMEOUT_EN
                    else if (wd_q == 5'(TO_CYC - 1)) begin
                        rdata_q     <= '0;
                        err_q       <= 1'b1;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        state_q     <= ST_RESP;
                    end else begin
                        wd_q <= wd_q + 5'd1;
                    end
`endif
                end
                ST_RESP: begin
                    ack_q[gid_q] <= 1'b1;
                    ptr_q        <= (gid_q == PW'(NREQ - 1)) ? '0 : gid_q + PW'(1);
                    state_q      <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign dbg_state = state_q;

endmodule
